// File: rtl/if_stage_pipe_pkg.sv
// Shared definitions for the fetch stage: FSM states, NOP word, register-field positions,
// PC increment and branch-target alignment.
package if_stage_pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int          RS1_LSB  = 15;
  localparam int          RS2_LSB  = 20;
  localparam logic [31:0] PC_INC   = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pipe_pc_reg.sv
// Program counter with write enable and next-PC selection (sequential increment or
// word-aligned branch redirect).
module pc_reg
  import if_stage_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  always_comb begin
    pc_next = redirect ? align_pc(target) : pc + PC_INC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (we) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage_pipe.sv
// Fetch stage with IF/ID register and IDLE/RUN fetch FSM.
// Optional IF_PERF_CNT_EN adds saturating stall/flush counters.
module if_stage_pipe
  import if_stage_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        mem_stall_i,
  input  logic        PCWrite_i,
  input  logic        IF_ID_Write_i,
  input  logic        Flush_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] IF_ID_pc_o,
  output logic [31:0] IF_ID_instr_o,
  output logic        IF_ID_valid_o,
  output logic [4:0]  IF_ID_RS1addr_o,
  output logic [4:0]  IF_ID_RS2addr_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  fetch_state_e state;
  logic         active;
  logic         row_stall;
  logic         row_hold;
  logic         row_flush;
  logic         row_fetch;
  logic         pc_we;

  // Fetch is live only while RUN and start_i is still high, so dropping start_i freezes at once.
  always_comb begin
    active    = (state == RUN) && start_i;
    row_stall = active && mem_stall_i;
    row_hold  = active && !mem_stall_i && !IF_ID_Write_i;
    row_flush = active && !mem_stall_i && IF_ID_Write_i && Flush_i;
    row_fetch = active && !mem_stall_i && IF_ID_Write_i && !Flush_i;
    pc_we     = row_flush || ((row_hold || row_fetch) && PCWrite_i);
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .we       (pc_we),
    .redirect (row_flush),
    .target   (branch_target_i),
    .pc       (pc_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= start_i ? RUN : IDLE;
    end
  end

  // IF/ID stage boundary
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      IF_ID_pc_o    <= 32'h0;
      IF_ID_instr_o <= NOP_INSTR;
      IF_ID_valid_o <= 1'b0;
    end else if (row_flush) begin
      IF_ID_pc_o    <= pc_o;
      IF_ID_instr_o <= NOP_INSTR;
      IF_ID_valid_o <= 1'b0;
    end else if (row_fetch) begin
      IF_ID_pc_o    <= pc_o;
      IF_ID_instr_o <= instr_i;
      IF_ID_valid_o <= 1'b1;
    end else if (!active) begin
      IF_ID_valid_o <= 1'b0;
    end
  end

  assign IF_ID_RS1addr_o = IF_ID_instr_o[RS1_LSB +: 5];
  assign IF_ID_RS2addr_o = IF_ID_instr_o[RS2_LSB +: 5];

`ifdef IF_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= 32'h0;
      flush_cnt_o <= 32'h0;
    end else begin
      if (row_stall || row_hold) stall_cnt_o <= sat_inc(stall_cnt_o);
      if (row_flush)             flush_cnt_o <= sat_inc(flush_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_pipe.sv
// Self-checking bench for if_stage_pipe: directed scenarios plus randomized control traffic
// compared against a cycle-level behavioural model. Counter checks run when IF_PERF_CNT_EN is defined.
module tb_if_stage_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        mem_stall_i;
  logic        PCWrite_i;
  logic        IF_ID_Write_i;
  logic        Flush_i;
  logic [31:0] branch_target_i;
  logic [31:0] instr_i;
  logic [31:0] pc_o;
  logic [31:0] IF_ID_pc_o;
  logic [31:0] IF_ID_instr_o;
  logic        IF_ID_valid_o;
  logic [4:0]  IF_ID_RS1addr_o;
  logic [4:0]  IF_ID_RS2addr_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h0000_5A13;
  endfunction

  assign instr_i = imem(pc_o);

  if_stage_pipe #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .mem_stall_i     (mem_stall_i),
    .PCWrite_i       (PCWrite_i),
    .IF_ID_Write_i   (IF_ID_Write_i),
    .Flush_i         (Flush_i),
    .branch_target_i (branch_target_i),
    .instr_i         (instr_i),
    .pc_o            (pc_o),
    .IF_ID_pc_o      (IF_ID_pc_o),
    .IF_ID_instr_o   (IF_ID_instr_o),
    .IF_ID_valid_o   (IF_ID_valid_o),
    .IF_ID_RS1addr_o (IF_ID_RS1addr_o),
    .IF_ID_RS2addr_o (IF_ID_RS2addr_o)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
`endif
  );

  int checks = 0;
  int passed = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ifpc, m_instr;
  logic        m_valid, m_running;
  int          m_stalls, m_flushes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pc"},    pc_o,                    m_pc);
    chk({tag, "_ifpc"},  IF_ID_pc_o,              m_ifpc);
    chk({tag, "_instr"}, IF_ID_instr_o,           m_instr);
    chk({tag, "_valid"}, {31'b0, IF_ID_valid_o},  {31'b0, m_valid});
    chk({tag, "_rs1"},   {27'b0, IF_ID_RS1addr_o}, {27'b0, m_instr[19:15]});
    chk({tag, "_rs2"},   {27'b0, IF_ID_RS2addr_o}, {27'b0, m_instr[24:20]});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_instr = NOP; m_valid = 1'b0; m_running = 1'b0;
    m_stalls = 0; m_flushes = 0;
  endtask

  // One clock edge of the fetch stage, from the priority table.
  task automatic model_edge();
    if (!(m_running && start_i)) begin
      m_valid = 1'b0;
    end else if (mem_stall_i) begin
      m_stalls++;
    end else if (!IF_ID_Write_i) begin
      if (PCWrite_i) m_pc = m_pc + 32'd4;
      m_stalls++;
    end else if (Flush_i) begin
      m_ifpc = m_pc; m_instr = NOP; m_valid = 1'b0;
      m_pc = branch_target_i & 32'hFFFF_FFFC;
      m_flushes++;
    end else begin
      m_ifpc = m_pc; m_instr = imem(m_pc); m_valid = 1'b1;
      if (PCWrite_i) m_pc = m_pc + 32'd4;
    end
    m_running = start_i;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    mem_stall_i = 1'b0; PCWrite_i = 1'b1; IF_ID_Write_i = 1'b1;
    Flush_i = 1'b0; branch_target_i = 32'h0;
  endtask

  task automatic async_reset();
    #2;
    rst_i = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b1;
  endtask

  initial begin
    int guard;
    rst_i = 1'b0; start_i = 1'b0;
    idle_ctrl();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_pc_const", pc_o, 32'h0);
    chk("reset_instr_const", IF_ID_instr_o, NOP);

    rst_i = 1'b1;
    start_i = 1'b1;
    tick(); check_all("start_edge");
    chk("start_valid0", {31'b0, IF_ID_valid_o}, 32'd0);
    tick(); check_all("run1");
    chk("run1_pc4", pc_o, 32'd4);
    chk("run1_valid", {31'b0, IF_ID_valid_o}, 32'd1);
    tick(); check_all("run2");
    chk("run2_pc8", pc_o, 32'd8);
    chk("run2_ifpc4", IF_ID_pc_o, 32'd4);

    PCWrite_i = 1'b0; IF_ID_Write_i = 1'b0;
    tick(); check_all("hazard");
    chk("hazard_pc8", pc_o, 32'd8);
    idle_ctrl();
    tick(); check_all("resume");
    chk("resume_pc12", pc_o, 32'd12);
    chk("resume_ifpc8", IF_ID_pc_o, 32'd8);
    tick(); check_all("to16");

    Flush_i = 1'b1; branch_target_i = 32'h40;
    tick(); check_all("flush");
    chk("flush_pc40", pc_o, 32'h40);
    chk("flush_nop", IF_ID_instr_o, NOP);
    idle_ctrl();
    tick(); check_all("after_flush");

    Flush_i = 1'b1; branch_target_i = 32'h80; IF_ID_Write_i = 1'b0; PCWrite_i = 1'b0;
    tick(); check_all("flush_vs_hazard");
    chk("flush_vs_hazard_pc", pc_o, 32'h44);
    idle_ctrl();
    Flush_i = 1'b1; branch_target_i = 32'h80; mem_stall_i = 1'b1;
    tick(); check_all("flush_vs_stall");
    chk("flush_vs_stall_pc", pc_o, 32'h44);
    idle_ctrl();

    start_i = 1'b0;
    tick(); check_all("start_drop");
    chk("start_drop_valid", {31'b0, IF_ID_valid_o}, 32'd0);
    tick(); check_all("idle_hold");
    start_i = 1'b1;
    tick(); check_all("restart");

    // Misaligned target low bits must be discarded; then wrap to zero.
    Flush_i = 1'b1; branch_target_i = 32'hFFFF_FFFF;
    tick(); check_all("to_top");
    chk("to_top_pc", pc_o, 32'hFFFF_FFFC);
    idle_ctrl();
    tick(); check_all("wrap");
    chk("wrap_pc0", pc_o, 32'h0);
    chk("wrap_ifpc", IF_ID_pc_o, 32'hFFFF_FFFC);

    for (int i = 0; i < 400; i++) begin
      start_i         = ($urandom_range(0, 24) != 0);
      mem_stall_i     = ($urandom_range(0, 5) == 0);
      IF_ID_Write_i   = ($urandom_range(0, 4) != 0);
      PCWrite_i       = IF_ID_Write_i ? ($urandom_range(0, 5) != 0) : $urandom_range(0, 1) == 1;
      Flush_i         = ($urandom_range(0, 5) == 0);
      branch_target_i = $urandom;
      tick();
      check_all("rand");
    end
`ifdef IF_PERF_CNT_EN
    chk("rand_stall_cnt", stall_cnt_o, m_stalls);
    chk("rand_flush_cnt", flush_cnt_o, m_flushes);
`endif

    // Asynchronous reset in the middle of a stalled cycle at pc 0x24.
    idle_ctrl();
    start_i = 1'b1;
    async_reset();
    check_all("areset1");
    release_reset();
    guard = 0;
    while (m_pc != 32'h24 && guard < 20) begin
      tick();
      guard++;
    end
    chk("reach_24", pc_o, 32'h24);
    mem_stall_i = 1'b1;
    tick(); check_all("stall24");
    async_reset();
    check_all("areset_mid");
    chk("areset_mid_pc", pc_o, 32'h0);
    chk("areset_mid_instr", IF_ID_instr_o, NOP);
    idle_ctrl();
    release_reset();

`ifdef IF_PERF_CNT_EN
    chk("cnt_reset_stall", stall_cnt_o, 32'd0);
    chk("cnt_reset_flush", flush_cnt_o, 32'd0);
    tick();
    mem_stall_i = 1'b1; tick(); idle_ctrl();
    IF_ID_Write_i = 1'b0; tick(); idle_ctrl();
    Flush_i = 1'b1; branch_target_i = 32'h100; tick(); idle_ctrl();
    mem_stall_i = 1'b1; tick(); idle_ctrl();
    tick();
    Flush_i = 1'b1; branch_target_i = 32'h200; tick(); idle_ctrl();
    check_all("perf");
    chk("perf_stall3", stall_cnt_o, 32'd3);
    chk("perf_flush2", flush_cnt_o, 32'd2);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
